hls_channel_fifo: RTL and testbench
===================================

Name: hls_channel_fifo

Overview:
- Responder end of the HLS channel protocol: the storage element behind every channel that generated kernels write into and read from.
- Kernels drive `in_data`, `write_valid`, `read_valid` and `rst`, and sample `out_data`, `read_ready` and `write_ready`.
- The block is a registered-output FIFO with one-cycle-latency pops, matching the kernel schedule: the kernel waits for `read_ready`, pulses `read_valid`, then consumes `out_data` in the next state.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears the FIFO.
- in_data  input  WIDTH  write payload.
- write_valid  input  1  write request; accepted when write_ready=1 in the same cycle.
- read_valid  input  1  pop request; accepted when read_ready=1 in the same cycle.
- out_data  output  WIDTH  registered data of the most recent accepted pop.
- read_ready  output  1  FIFO is non-empty (count != 0).
- write_ready  output  1  FIFO is not full (count != DEPTH).
- count  output  CNT_W  current occupancy, for debug and the bench.

Behaviour:
- Reset (async assert, release synchronised by the surrounding design):
  - rd_ptr=0, wr_ptr=0, count=0, out_data=0.
  - Hence read_ready=0 and write_ready=1.
  - Storage array contents are don't-care after reset.
- Ready flags are combinational from count only; they never depend on the valid inputs (no combinational loop through a kernel).
- Write accept (write_valid && write_ready):
  - mem[wr_ptr] <= in_data.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop accept (read_valid && read_ready):
  - out_data <= mem[rd_ptr].
  - rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
  - The popped value is visible on out_data from the cycle after the pop and held until the next accepted pop.
- count update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Ignored requests:
  - write_valid while full: ignored; no pointer, count or data change.
  - read_valid while empty: ignored; out_data holds its previous value.
- Simultaneous write and pop:
  - When count in 1..DEPTH-1, both are accepted.
  - When full, only the pop is accepted (write_ready=0 that cycle); the write is dropped, and the kernel must retry after observing write_ready.
  - When empty, only the write is accepted; there is no write-to-read bypass. read_ready rises the following cycle.
- No first-word fall-through: out_data never reflects the head before a pop.
- Latencies:
  - Write to read_ready high: 1 cycle.
  - Pop to data valid on out_data: 1 cycle.
- Reset asserted mid-operation: all state is cleared immediately (async); in-flight accepts in that cycle are discarded.
- No internal FSM beyond the pointer/count datapath. The protocol obligations sit on the kernel side:
  - wait for ready;
  - pulse valid for exactly one cycle;
  - consume out_data one cycle later.

Decomposition:
- Shared package: channel handshake constants (`CHAN_WIDTH_DEFAULT=32`, `CHAN_DEPTH_DEFAULT=16`) and a helper function for the pointer width.
- One natural sub-module, `hls_channel_mem`: DEPTH x WIDTH storage with one synchronous write port and one synchronous read port (raddr, rdata registered, ren).
- The top level holds the pointers, count, flags and accept logic.

Test Plan:
- Reset then idle -> read_ready=0, write_ready=1, count=0, out_data=0; read_valid pulses are ignored and out_data stays 0.
- Write 1,2,3,4, then four one-cycle read_valid pulses spaced like the kernel (wait ready, pulse, consume) -> out_data shows 1,2,3,4, each one cycle after its pulse; a summing reader totals 10; count ends at 0.
- Fill DEPTH=16 with 0..15 -> write_ready=0 at count=16; a 17th write of 99 is dropped; draining yields 0..15 in order, and 99 is never seen.
- Pointer wrap: write 10, pop 10, then write 100..115 and pop 16 -> values 100..115 in order across the wrap; count returns to 0.
- Simultaneous events:
  - write+pop at count=5 -> count stays 5, out_data is the old head.
  - write+pop at full -> count=15, write dropped.
  - write+pop at empty -> count=1, out_data unchanged.
- Async rst asserted mid-stream at count=7, between clock edges -> outputs clear immediately (count=0, read_ready=0, out_data=0); after release, a write of 0xDEADBEEF then a pop returns 0xDEADBEEF.

Source files
------------

// File: rtl/hls_channel_fifo_pkg.sv
// Shared constants and helpers for the HLS channel FIFO.
// Everything that sizes a channel is derived from the defaults and helper here.
package hls_channel_fifo_pkg;

    localparam int CHAN_WIDTH_DEFAULT = 32;
    localparam int CHAN_DEPTH_DEFAULT = 16;

    // Pointer width for a power-of-two depth; wrap comes for free from overflow.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/hls_channel_fifo_if.sv
// Handshake bundle between a generated kernel (master) and the channel FIFO (slave).
interface hls_channel_fifo_if
    import hls_channel_fifo_pkg::*;
#(
    parameter int WIDTH = CHAN_WIDTH_DEFAULT,
    parameter int DEPTH = CHAN_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
);

    logic [WIDTH-1:0] in_data;
    logic             write_valid;
    logic             read_valid;
    logic [WIDTH-1:0] out_data;
    logic             read_ready;
    logic             write_ready;
    logic [CNT_W-1:0] count;

    modport master (
        output in_data,
        output write_valid,
        output read_valid,
        input  out_data,
        input  read_ready,
        input  write_ready,
        input  count
    );

    modport slave (
        input  in_data,
        input  write_valid,
        input  read_valid,
        output out_data,
        output read_ready,
        output write_ready,
        output count
    );

endinterface

// File: rtl/hls_channel_fifo_mem.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
// Only the read register is reset; the array contents are don't-care after reset.
module hls_channel_mem
    import hls_channel_fifo_pkg::*;
#(
    parameter int WIDTH  = CHAN_WIDTH_DEFAULT,
    parameter int DEPTH  = CHAN_DEPTH_DEFAULT,
    parameter int ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata doubles as the FIFO's out_data, so it holds between pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hls_channel_fifo.sv
// Registered-output channel FIFO with one-cycle pop latency and no fall-through.
// Ready flags come from the occupancy count only, never from the valid inputs.
module hls_channel_fifo
    import hls_channel_fifo_pkg::*;
#(
    parameter int WIDTH = CHAN_WIDTH_DEFAULT,
    parameter int DEPTH = CHAN_DEPTH_DEFAULT,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    hls_channel_fifo_if.slave  ch
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             read_ready;
    logic             write_ready;
    logic             wr_acc;
    logic             rd_acc;

    assign read_ready  = (count_q != '0);
    assign write_ready = (count_q != CNT_W'(DEPTH));

    // At count 0 or DEPTH only one side can be accepted, so the array never
    // sees a read and a write to the same entry in one cycle.
    assign wr_acc = ch.write_valid && write_ready;
    assign rd_acc = ch.read_valid  && read_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    hls_channel_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(ch.in_data),
        .ren  (rd_acc),
        .raddr(rd_ptr),
        .rdata(ch.out_data)
    );

    assign ch.read_ready  = read_ready;
    assign ch.write_ready = write_ready;
    assign ch.count       = count_q;

endmodule

// File: tb/tb_hls_channel_fifo.sv
// Bench for hls_channel_fifo: directed scenarios plus random traffic against a queue model.
module tb_hls_channel_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hls_channel_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) ch ();

    hls_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .ch (ch)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO contents as a queue, plus the last popped value.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_out;

    // One clock of stimulus; inputs change 1 time unit after the edge.
    task automatic step(input bit wv, input logic [WIDTH-1:0] d, input bit rv);
        bit do_w;
        bit do_r;
        ch.in_data     = d;
        ch.write_valid = wv;
        ch.read_valid  = rv;
        do_w = wv && (model_q.size() < DEPTH);
        do_r = rv && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_r) exp_out = model_q.pop_front();
        if (do_w) model_q.push_back(d);
        ch.write_valid = 1'b0;
        ch.read_valid  = 1'b0;
    endtask

    task automatic apply_reset();
        ch.in_data     = '0;
        ch.write_valid = 1'b0;
        ch.read_valid  = 1'b0;
        rst = 1'b1;
        model_q.delete();
        exp_out = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (ch.read_ready !== 1'b0 || ch.write_ready !== 1'b1 || ch.count !== '0 || ch.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rr=%b wr=%b cnt=%0d out=%h, required rr=0 wr=1 cnt=0 out=0",
                     ch.read_ready, ch.write_ready, ch.count, ch.out_data);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (ch.out_data !== '0 || ch.count !== '0) begin
                n_fail++;
                $display("FAIL empty_pop_ignored: out=%h cnt=%0d, required out=0 cnt=0", ch.out_data, ch.count);
            end
        end
    endtask

    task automatic test_basic();
        int sum = 0;
        int waited;
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0);
        n_cmp++;
        if (ch.count !== 5'd4 || ch.read_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_count4: cnt=%0d rr=%b, required cnt=4 rr=1", ch.count, ch.read_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            waited = 0;
            while (ch.read_ready !== 1'b1 && waited < 20) begin
                step(1'b0, '0, 1'b0);
                waited++;
            end
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (ch.out_data !== WIDTH'(i)) begin
                n_fail++;
                $display("FAIL basic_pop%0d: out=%0d, required %0d", i, ch.out_data, i);
            end
            sum += int'(ch.out_data);
            step(1'b0, '0, 1'b0);
        end
        n_cmp++;
        if (sum != 10 || ch.count !== '0) begin
            n_fail++;
            $display("FAIL basic_sum: sum=%0d cnt=%0d, required sum=10 cnt=0", sum, ch.count);
        end
    endtask

    task automatic test_fill();
        bit saw99 = 1'b0;
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        n_cmp++;
        if (ch.write_ready !== 1'b0 || ch.count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_full: wr=%b cnt=%0d, required wr=0 cnt=16", ch.write_ready, ch.count);
        end
        step(1'b1, WIDTH'(99), 1'b0);
        n_cmp++;
        if (ch.count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill_drop: cnt=%0d, required 16", ch.count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1);
            if (ch.out_data === WIDTH'(99)) saw99 = 1'b1;
            n_cmp++;
            if (ch.out_data !== WIDTH'(i)) begin
                n_fail++;
                $display("FAIL fill_drain%0d: out=%0d, required %0d", i, ch.out_data, i);
            end
        end
        n_cmp++;
        if (saw99 || ch.count !== '0 || ch.write_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_end: saw99=%b cnt=%0d wr=%b, required saw99=0 cnt=0 wr=1", saw99, ch.count, ch.write_ready);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, WIDTH'(100 + i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (ch.out_data !== WIDTH'(100 + i)) begin
                n_fail++;
                $display("FAIL wrap_pop%0d: out=%0d, required %0d", i, ch.out_data, 100 + i);
            end
        end
        n_cmp++;
        if (ch.count !== '0) begin
            n_fail++;
            $display("FAIL wrap_count: cnt=%0d, required 0", ch.count);
        end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] prev;
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(200 + i), 1'b0);
        step(1'b1, WIDTH'(300), 1'b1);
        n_cmp++;
        if (ch.count !== 5'd5 || ch.out_data !== WIDTH'(200)) begin
            n_fail++;
            $display("FAIL simul_mid: cnt=%0d out=%0d, required cnt=5 out=200", ch.count, ch.out_data);
        end
        for (int i = 0; i < 11; i++) step(1'b1, WIDTH'(400 + i), 1'b0);
        step(1'b1, WIDTH'(77), 1'b1);
        n_cmp++;
        if (ch.count !== 5'd15 || ch.out_data !== WIDTH'(201) || ch.write_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_full: cnt=%0d out=%0d wr=%b, required cnt=15 out=201 wr=1", ch.count, ch.out_data, ch.write_ready);
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, '0, 1'b1);
            n_cmp++;
            if (ch.out_data !== exp_out || ch.out_data === WIDTH'(77)) begin
                n_fail++;
                $display("FAIL simul_drain%0d: out=%0d, required %0d", i, ch.out_data, exp_out);
            end
        end
        prev = ch.out_data;
        step(1'b1, WIDTH'(555), 1'b1);
        n_cmp++;
        if (ch.count !== 5'd1 || ch.out_data !== prev || ch.read_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_empty: cnt=%0d out=%0d rr=%b, required cnt=1 out=%0d rr=1", ch.count, ch.out_data, ch.read_ready, prev);
        end
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (ch.out_data !== WIDTH'(555)) begin
            n_fail++;
            $display("FAIL simul_empty_pop: out=%0d, required 555", ch.out_data);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(32'h1000 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (ch.count !== 5'd7 || ch.out_data !== WIDTH'(32'h1000)) begin
            n_fail++;
            $display("FAIL arst_pre: cnt=%0d out=%h, required cnt=7 out=1000", ch.count, ch.out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ch.count !== '0 || ch.read_ready !== 1'b0 || ch.out_data !== '0 || ch.write_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_clear: cnt=%0d rr=%b wr=%b out=%h, required cnt=0 rr=0 wr=1 out=0",
                     ch.count, ch.read_ready, ch.write_ready, ch.out_data);
        end
        model_q.delete();
        exp_out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'hDEADBEEF, 1'b0);
        step(1'b0, '0, 1'b1);
        n_cmp++;
        if (ch.out_data !== 32'hDEADBEEF || ch.count !== '0) begin
            n_fail++;
            $display("FAIL arst_after: out=%h cnt=%0d, required out=deadbeef cnt=0", ch.out_data, ch.count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
            n_cmp++;
            if (ch.count !== 5'(model_q.size()) || ch.out_data !== exp_out ||
                ch.read_ready !== (model_q.size() != 0) || ch.write_ready !== (model_q.size() != DEPTH)) begin
                n_fail++;
                $display("FAIL random%0d: cnt=%0d out=%h rr=%b wr=%b, required cnt=%0d out=%h",
                         i, ch.count, ch.out_data, ch.read_ready, ch.write_ready, model_q.size(), exp_out);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_out = '0;
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
